// File: rtl/kovan_cmd_pkg.sv
// Shared command-map definitions for the Kovan servo path.
// Holds the servo word width, the reset/clamp constants, the channel count
// and the command-register slot numbers that feed servo_pwm_gen.
// No ports (package).
package kovan_cmd_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = 16'd20000;
  localparam logic [CNT_W-1:0] MIN_PULSE      = 16'd500;
  localparam logic [CNT_W-1:0] MAX_PULSE      = 16'd2500;

  // Command register word indices for the servo block.
  typedef enum logic [4:0] {
    CMD_SLOT_SERVO_PERIOD = 5'd24,
    CMD_SLOT_SERVO_PULSE0 = 5'd25,
    CMD_SLOT_SERVO_PULSE1 = 5'd26,
    CMD_SLOT_SERVO_PULSE2 = 5'd27,
    CMD_SLOT_SERVO_PULSE3 = 5'd28,
    CMD_SLOT_SERVO_ENABLE = 5'd29
  } servo_slot_e;

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo PWM channel.
// Holds the shadow pulse width and enable, the clamp logic applied when the
// shadow is loaded, the frame-counter comparator and the output register.
// Ports:
//   SYS_CLK, RST_N  clock, asynchronous active-low reset
//   i_load          shadow load strobe from the top-level timebase
//   i_run           latched period is usable (>=2); outputs forced low otherwise
//   i_cnt           shared frame counter
//   i_cmd_pulse     requested pulse width, ticks
//   i_cmd_en        requested channel enable
//   o_servo         registered PWM output
//   o_clamp         shadow pulse was clamped at the last load
module servo_pwm_chan
  import kovan_cmd_pkg::*;
#(
  parameter int               CNT_W     = kovan_cmd_pkg::CNT_W,
  parameter logic [CNT_W-1:0] MIN_PULSE = CNT_W'(kovan_cmd_pkg::MIN_PULSE),
  parameter logic [CNT_W-1:0] MAX_PULSE = CNT_W'(kovan_cmd_pkg::MAX_PULSE)
) (
  input  logic             SYS_CLK,
  input  logic             RST_N,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_cmd_pulse,
  input  logic             i_cmd_en,
  output logic             o_servo,
  output logic             o_clamp
);

  logic [CNT_W-1:0] r_pul_sh;
  logic             r_en_sh;
  logic             r_servo;
  logic             r_clamp;
  logic [CNT_W:0]   w_clamped;

  // Returns {clamped_flag, width}. Zero is an explicit "off" and is not clamped.
  function automatic logic [CNT_W:0] clamp_pulse(input logic [CNT_W-1:0] p);
    if (p == '0)
      return {1'b0, p};
    else if (p < MIN_PULSE)
      return {1'b1, MIN_PULSE};
    else if (p > MAX_PULSE)
      return {1'b1, MAX_PULSE};
    else
      return {1'b0, p};
  endfunction

  assign w_clamped = clamp_pulse(i_cmd_pulse);

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pul_sh <= '0;
      r_en_sh  <= 1'b0;
      r_clamp  <= 1'b0;
      r_servo  <= 1'b0;
    end else begin
      if (i_load) begin
        r_pul_sh <= w_clamped[CNT_W-1:0];
        r_en_sh  <= i_cmd_en;
        r_clamp  <= w_clamped[CNT_W];
      end
      // A width >= period keeps the comparison true for every count, so the
      // output stays high across the wrap with no gap.
      r_servo <= i_run && r_en_sh && (i_cnt < r_pul_sh);
    end
  end

  assign o_servo = r_servo;
  assign o_clamp = r_clamp;

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo pulse generator.
// A prescaler divides SYS_CLK into timebase ticks; a frame counter runs over
// the latched period; per-channel shadows are reloaded only at frame
// boundaries so command changes never disturb a pulse in progress.
// Ports:
//   SYS_CLK     system clock (rising edge)
//   RST_N       asynchronous active-low reset
//   CMD_PERIOD  requested frame period, ticks
//   CMD_PULSE   packed pulse widths, ch i = [i*CNT_W +: CNT_W]
//   CMD_ENABLE  per-channel enable
//   SERVO_OUT   PWM outputs, active high
//   FRAME_TICK  one-cycle pulse after each frame wrap
//   CLAMP_FLAG  ch i pulse was clamped at the last shadow load
module servo_pwm_gen
  import kovan_cmd_pkg::*;
#(
  parameter int               NUM_CH         = kovan_cmd_pkg::NUM_CH,
  parameter int               PRESCALE       = 48,
  parameter int               CNT_W          = kovan_cmd_pkg::CNT_W,
  parameter logic [CNT_W-1:0] MIN_PULSE      = CNT_W'(kovan_cmd_pkg::MIN_PULSE),
  parameter logic [CNT_W-1:0] MAX_PULSE      = CNT_W'(kovan_cmd_pkg::MAX_PULSE),
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(kovan_cmd_pkg::DEFAULT_PERIOD)
) (
  input  logic                    SYS_CLK,
  input  logic                    RST_N,
  input  logic [CNT_W-1:0]        CMD_PERIOD,
  input  logic [NUM_CH*CNT_W-1:0] CMD_PULSE,
  input  logic [NUM_CH-1:0]       CMD_ENABLE,
  output logic [NUM_CH-1:0]       SERVO_OUT,
  output logic                    FRAME_TICK,
  output logic [NUM_CH-1:0]       CLAMP_FLAG
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per_sh;
  logic             r_first;
  logic             r_frame_tick;

  logic w_tick;
  logic w_run;
  logic w_wrap;
  logic w_load;

  assign w_tick = (r_pre == PRE_LAST);
  // Periods of 0 or 1 park the counter and silence the outputs.
  assign w_run  = (r_per_sh >= CNT_W'(2));
  assign w_wrap = w_tick && w_run && (r_cnt == (r_per_sh - CNT_W'(1)));
  // Reload on the first tick after reset, on every wrap, and on every tick
  // while parked so a usable period is picked up as soon as it appears.
  assign w_load = w_tick && (r_first || !w_run || w_wrap);

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre        <= '0;
      r_cnt        <= '0;
      r_per_sh     <= DEFAULT_PERIOD;
      r_first      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
      r_pre        <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        if (w_load) begin
          r_per_sh <= CMD_PERIOD;
          r_first  <= 1'b0;
        end
        // The first load after reset starts a fresh frame at count 0.
        if (r_first || !w_run || w_wrap)
          r_cnt <= '0;
        else
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign FRAME_TICK = r_frame_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    servo_pwm_chan #(
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE)
    ) u_chan (
      .SYS_CLK     (SYS_CLK),
      .RST_N       (RST_N),
      .i_load      (w_load),
      .i_run       (w_run),
      .i_cnt       (r_cnt),
      .i_cmd_pulse (CMD_PULSE[g*CNT_W +: CNT_W]),
      .i_cmd_en    (CMD_ENABLE[g]),
      .o_servo     (SERVO_OUT[g]),
      .o_clamp     (CLAMP_FLAG[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
module tb_servo_pwm_gen;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 4;

  logic                    SYS_CLK = 1'b0;
  logic                    RST_N   = 1'b1;
  logic [CNT_W-1:0]        CMD_PERIOD = '0;
  logic [NUM_CH*CNT_W-1:0] CMD_PULSE  = '0;
  logic [NUM_CH-1:0]       CMD_ENABLE = '0;
  logic [NUM_CH-1:0]       SERVO_OUT;
  logic                    FRAME_TICK;
  logic [NUM_CH-1:0]       CLAMP_FLAG;

  servo_pwm_gen #(
    .NUM_CH         (NUM_CH),
    .PRESCALE       (PRESCALE),
    .CNT_W          (CNT_W),
    .MIN_PULSE      (16'd5),
    .MAX_PULSE      (16'd50),
    .DEFAULT_PERIOD (16'd20000)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .RST_N      (RST_N),
    .CMD_PERIOD (CMD_PERIOD),
    .CMD_PULSE  (CMD_PULSE),
    .CMD_ENABLE (CMD_ENABLE),
    .SERVO_OUT  (SERVO_OUT),
    .FRAME_TICK (FRAME_TICK),
    .CLAMP_FLAG (CLAMP_FLAG)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Commands currently driven.
  int         c_per;
  int         c_pul[NUM_CH];
  logic [3:0] c_en;

  // Frame measurement results.
  int m_len;
  int m_hi[NUM_CH];
  int m_last[NUM_CH];
  bit m_to;

  // Optional command change applied inside a measured frame.
  int         m_chg_at = -1;
  int         m_chg_per;
  int         m_chg_pul[NUM_CH];
  logic [3:0] m_chg_en;

  // Reference: clocks of high output per frame from the command values.
  function automatic int exp_hi(input int per, input int p, input bit en);
    int w;
    if (!en || p == 0) return 0;
    w = (p < 5) ? 5 : ((p > 50) ? 50 : p);
    if (w > per) w = per;
    return w * PRESCALE;
  endfunction

  function automatic bit exp_flag(input int p);
    return (p != 0) && ((p < 5) || (p > 50));
  endfunction

  task automatic drive_cmd(input int per, input int p0, input int p1, input int p2,
                           input int p3, input logic [3:0] en);
    c_per = per;
    c_pul[0] = p0; c_pul[1] = p1; c_pul[2] = p2; c_pul[3] = p3;
    c_en = en;
    CMD_PERIOD = CNT_W'(per);
    CMD_PULSE  = {CNT_W'(p3), CNT_W'(p2), CNT_W'(p1), CNT_W'(p0)};
    CMD_ENABLE = en;
  endtask

  // Advance to the sample where FRAME_TICK is high.
  task automatic sync_frame();
    int n;
    n = 0;
    m_to = 0;
    do begin
      @(negedge SYS_CLK);
      n++;
      if (n > 5000) m_to = 1;
    end while (!FRAME_TICK && !m_to);
  endtask

  // Called at a FRAME_TICK sample; samples the next frame up to and including
  // its FRAME_TICK sample (outputs lag the counter by one clock).
  task automatic measure_frame();
    bit done;
    done  = 0;
    m_len = 0;
    m_to  = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_hi[c] = 0;
      m_last[c] = 0;
    end
    while (!done) begin
      @(negedge SYS_CLK);
      m_len++;
      for (int c = 0; c < NUM_CH; c++)
        if (SERVO_OUT[c]) begin
          m_hi[c]++;
          m_last[c] = m_len;
        end
      if (FRAME_TICK)
        done = 1;
      else if (m_len == m_chg_at)
        drive_cmd(m_chg_per, m_chg_pul[0], m_chg_pul[1], m_chg_pul[2], m_chg_pul[3], m_chg_en);
      if (m_len > 5000) begin
        m_to = 1;
        done = 1;
      end
    end
    m_chg_at = -1;
  endtask

  task automatic test_reset();
    int bad;
    drive_cmd(100, 20, 0, 0, 0, 4'hF);
    #1 RST_N = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge SYS_CLK);
      if ({SERVO_OUT, FRAME_TICK, CLAMP_FLAG} !== 9'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs bad_samples=%0d required=0 last=%b", bad,
               {SERVO_OUT, FRAME_TICK, CLAMP_FLAG});
    end
    RST_N = 1'b1;
  endtask

  task automatic test_steady();
    sync_frame();
    n_checks++;
    if (m_to !== 0) begin n_fail++; $display("FAIL steady_sync timeout got=1 required=0"); end
    for (int f = 0; f < 2; f++) begin
      measure_frame();
      n_checks++;
      if (m_len !== 400) begin
        n_fail++; $display("FAIL steady_frame_len frame=%0d got=%0d required=400", f, m_len);
      end
      n_checks++;
      if (m_hi[0] !== 80 || m_last[0] !== 80) begin
        n_fail++; $display("FAIL steady_pulse0 hi=%0d last=%0d required=80", m_hi[0], m_last[0]);
      end
      for (int c = 1; c < NUM_CH; c++) begin
        n_checks++;
        if (m_hi[c] !== 0) begin
          n_fail++; $display("FAIL steady_zero_ch%0d got=%0d required=0", c, m_hi[c]);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    m_chg_at  = 10 * PRESCALE;
    m_chg_per = 100;
    m_chg_pul[0] = 40; m_chg_pul[1] = 0; m_chg_pul[2] = 0; m_chg_pul[3] = 0;
    m_chg_en  = c_en;
    measure_frame();
    n_checks++;
    if (m_hi[0] !== 80 || m_last[0] !== 80) begin
      n_fail++; $display("FAIL dbuf_current hi=%0d last=%0d required=80", m_hi[0], m_last[0]);
    end
    measure_frame();
    n_checks++;
    if (m_hi[0] !== 160 || m_last[0] !== 160) begin
      n_fail++; $display("FAIL dbuf_next hi=%0d last=%0d required=160", m_hi[0], m_last[0]);
    end
  endtask

  task automatic test_clamp();
    int vals[3];
    vals[0] = 2; vals[1] = 60; vals[2] = 0;
    for (int k = 0; k < 3; k++) begin
      m_chg_at  = 7;
      m_chg_per = 100;
      m_chg_pul[0] = 40; m_chg_pul[1] = vals[k]; m_chg_pul[2] = 0; m_chg_pul[3] = 0;
      m_chg_en  = 4'hF;
      measure_frame();
      measure_frame();
      n_checks++;
      if (m_hi[1] !== exp_hi(100, vals[k], 1'b1) || m_last[1] !== exp_hi(100, vals[k], 1'b1)) begin
        n_fail++; $display("FAIL clamp_width p=%0d hi=%0d last=%0d required=%0d", vals[k],
                           m_hi[1], m_last[1], exp_hi(100, vals[k], 1'b1));
      end
      n_checks++;
      if (CLAMP_FLAG !== {2'b00, exp_flag(vals[k]), 1'b0}) begin
        n_fail++; $display("FAIL clamp_flag p=%0d got=%b required=%b", vals[k], CLAMP_FLAG,
                           {2'b00, exp_flag(vals[k]), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    int         o_per;
    int         o_pul[NUM_CH];
    logic [3:0] o_en;
    logic [3:0] e_flag;
    int         e;
    for (int it = 0; it < 8; it++) begin
      o_per = c_per; o_pul = c_pul; o_en = c_en;
      m_chg_per = int'($urandom_range(10, 60));
      for (int c = 0; c < NUM_CH; c++)
        m_chg_pul[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 70));
      m_chg_en = 4'($urandom_range(0, 15));
      m_chg_at = int'($urandom_range(1, o_per * PRESCALE - 1));
      measure_frame();
      n_checks++;
      if (m_to !== 0 || m_len !== o_per * PRESCALE) begin
        n_fail++; $display("FAIL rand_old_len it=%0d got=%0d required=%0d", it, m_len, o_per * PRESCALE);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        e = exp_hi(o_per, o_pul[c], o_en[c]);
        n_checks++;
        if (m_hi[c] !== e || m_last[c] !== e) begin
          n_fail++; $display("FAIL rand_old_ch%0d it=%0d hi=%0d last=%0d required=%0d", c, it,
                             m_hi[c], m_last[c], e);
        end
      end
      measure_frame();
      n_checks++;
      if (m_to !== 0 || m_len !== c_per * PRESCALE) begin
        n_fail++; $display("FAIL rand_new_len it=%0d got=%0d required=%0d", it, m_len, c_per * PRESCALE);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        e = exp_hi(c_per, c_pul[c], c_en[c]);
        e_flag[c] = exp_flag(c_pul[c]);
        n_checks++;
        if (m_hi[c] !== e || m_last[c] !== e) begin
          n_fail++; $display("FAIL rand_new_ch%0d it=%0d hi=%0d last=%0d required=%0d", c, it,
                             m_hi[c], m_last[c], e);
        end
      end
      n_checks++;
      if (CLAMP_FLAG !== e_flag) begin
        n_fail++; $display("FAIL rand_flags it=%0d got=%b required=%b", it, CLAMP_FLAG, e_flag);
      end
    end
  endtask

  task automatic test_edge_period();
    int bad;
    drive_cmd(0, c_pul[0], c_pul[1], c_pul[2], c_pul[3], 4'hF);
    sync_frame();
    n_checks++;
    if (m_to !== 0) begin n_fail++; $display("FAIL edge_sync timeout got=1 required=0"); end
    bad = 0;
    repeat (200) begin
      @(negedge SYS_CLK);
      if (FRAME_TICK !== 1'b0 || SERVO_OUT !== 4'h0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL edge_period0 bad_samples=%0d required=0", bad);
    end
    drive_cmd(30, 50, 50, 50, 50, 4'hF);
    repeat (8) @(negedge SYS_CLK);
    bad = 0;
    repeat (300) begin
      @(negedge SYS_CLK);
      if (SERVO_OUT !== 4'hF || CLAMP_FLAG !== 4'h0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL edge_full_high bad_samples=%0d required=0", bad);
    end
    sync_frame();
    measure_frame();
    n_checks++;
    if (m_to !== 0 || m_len !== 120) begin
      n_fail++; $display("FAIL edge_p30_len got=%0d required=120", m_len);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (m_hi[c] !== exp_hi(30, 50, 1'b1)) begin
        n_fail++; $display("FAIL edge_p30_ch%0d hi=%0d required=%0d", c, m_hi[c], exp_hi(30, 50, 1'b1));
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cmd(100, 20, 0, 0, 0, 4'h1);
    sync_frame();
    sync_frame();
    repeat (20) @(negedge SYS_CLK);
    n_checks++;
    if (SERVO_OUT !== 4'b0001) begin
      n_fail++; $display("FAIL arst_pre got=%b required=0001", SERVO_OUT);
    end
    #1 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({SERVO_OUT, FRAME_TICK, CLAMP_FLAG} !== 9'b0) begin
      n_fail++; $display("FAIL arst_async got=%b required=0", {SERVO_OUT, FRAME_TICK, CLAMP_FLAG});
    end
    repeat (3) @(negedge SYS_CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge SYS_CLK);
      n_checks++;
      if (SERVO_OUT !== {3'b000, (k >= 5)} || FRAME_TICK !== 1'b0) begin
        n_fail++; $display("FAIL arst_restart cycle=%0d got=%b/%b required=%b/0", k, SERVO_OUT,
                           FRAME_TICK, {3'b000, (k >= 5)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_double_buffer();
    test_clamp();
    test_random();
    test_edge_period();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
